// File: rtl/snn_mem_pkg.sv
// Shared constants and requester identifiers for the SNN state/weight DFFRAM.
package snn_mem_pkg;

  localparam int SNN_RAM_ADDR_W = 8;
  localparam int SNN_RAM_DATA_W = 32;
  localparam int SNN_RAM_NB     = 4;

  typedef enum logic {
    REQ_M0 = 1'b0,
    REQ_M1 = 1'b1
  } req_id_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way arbiter: round-robin on contention, or m0-first when FIXED_PRIO is set.
module rr_arb2
  import snn_mem_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  req_id_e last_gnt_reg;
  req_id_e last_gnt_next;

  always_comb begin
    gnt           = 2'b00;
    last_gnt_next = last_gnt_reg;
    if (!RST) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11: begin
          // On contention the side that did not win last time goes first.
          if (FIXED_PRIO != 0 || last_gnt_reg == REQ_M1) gnt = 2'b01;
          else                                           gnt = 2'b10;
        end
        default: gnt = 2'b00;
      endcase
      if (gnt[0])      last_gnt_next = REQ_M0;
      else if (gnt[1]) last_gnt_next = REQ_M1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) last_gnt_reg <= REQ_M1;
    else     last_gnt_reg <= last_gnt_next;
  end

endmodule

// File: rtl/dffram_arbiter.sv
// Shares one single-port DFFRAM between two requesters; returns reads one cycle
// after grant and holds each requester's last read word while the RAM idles.
module dffram_arbiter
  import snn_mem_pkg::*;
#(
  parameter int FIXED_PRIO = 0,
  parameter int ADDR_W     = SNN_RAM_ADDR_W,
  parameter int DATA_W     = SNN_RAM_DATA_W,
  localparam int NB        = DATA_W / 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              m0_req,
  input  logic [NB-1:0]     m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic [NB-1:0]     m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              ram_en,
  output logic [NB-1:0]     ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_di,
  input  logic [DATA_W-1:0] ram_do
);

  logic [1:0]        gnt;
  logic [NB-1:0]     we_arr    [2];
  logic [ADDR_W-1:0] addr_arr  [2];
  logic [DATA_W-1:0] wdata_arr [2];
  logic [DATA_W-1:0] rdata_arr [2];
  logic [DATA_W-1:0] hold_reg  [2];
  logic [DATA_W-1:0] hold_next [2];
  logic [1:0]        rd_pend_reg;
  logic [1:0]        rd_pend_next;

  assign we_arr[0]    = m0_we;
  assign we_arr[1]    = m1_we;
  assign addr_arr[0]  = m0_addr;
  assign addr_arr[1]  = m1_addr;
  assign wdata_arr[0] = m0_wdata;
  assign wdata_arr[1] = m1_wdata;

  rr_arb2 #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_arb (
    .CLK (CLK),
    .RST (RST),
    .req ({m1_req, m0_req}),
    .gnt (gnt)
  );

  assign m0_gnt = gnt[0];
  assign m1_gnt = gnt[1];

  // Idle port is driven to all-zero so the macro sees a quiet bus.
  always_comb begin
    ram_en   = 1'b0;
    ram_we   = '0;
    ram_addr = '0;
    ram_di   = '0;
    if (gnt[0]) begin
      ram_en   = 1'b1;
      ram_we   = we_arr[0];
      ram_addr = addr_arr[0];
      ram_di   = wdata_arr[0];
    end else if (gnt[1]) begin
      ram_en   = 1'b1;
      ram_we   = we_arr[1];
      ram_addr = addr_arr[1];
      ram_di   = wdata_arr[1];
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
      assign rd_pend_next[gi] = gnt[gi] && (we_arr[gi] == '0);
      // The macro output returns to zero once disabled, so keep a private copy.
      assign hold_next[gi]    = rd_pend_reg[gi] ? ram_do : hold_reg[gi];
      assign rdata_arr[gi]    = rd_pend_reg[gi] ? ram_do : hold_reg[gi];
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_pend_reg <= 2'b00;
      hold_reg[0] <= '0;
      hold_reg[1] <= '0;
    end else begin
      rd_pend_reg <= rd_pend_next;
      hold_reg[0] <= hold_next[0];
      hold_reg[1] <= hold_next[1];
    end
  end

  assign m0_rvalid = rd_pend_reg[0];
  assign m1_rvalid = rd_pend_reg[1];
  assign m0_rdata  = rdata_arr[0];
  assign m1_rdata  = rdata_arr[1];

endmodule

// File: tb/tb_dffram_arbiter.sv
// Scoreboard bench: round-robin DUT fully checked against a queue/array model,
// a fixed-priority DUT on the same stimulus checked for grants.
module tb_dffram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 1'b0, m1_req = 1'b0;
  logic [3:0]  m0_we = '0, m1_we = '0;
  logic [7:0]  m0_addr = '0, m1_addr = '0;
  logic [31:0] m0_wdata = '0, m1_wdata = '0;

  logic        m0_gnt_a, m1_gnt_a, m0_rvalid_a, m1_rvalid_a, ram_en_a;
  logic [31:0] m0_rdata_a, m1_rdata_a, ram_di_a, ram_do_a;
  logic [3:0]  ram_we_a;
  logic [7:0]  ram_addr_a;

  logic        m0_gnt_b, m1_gnt_b, m0_rvalid_b, m1_rvalid_b, ram_en_b;
  logic [31:0] m0_rdata_b, m1_rdata_b, ram_di_b;
  logic [3:0]  ram_we_b;
  logic [7:0]  ram_addr_b;

  always #5 clk = ~clk;

  dffram_arbiter #(.FIXED_PRIO(0)) u_rr (
    .CLK(clk), .RST(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt_a), .m0_rvalid(m0_rvalid_a), .m0_rdata(m0_rdata_a),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt_a), .m1_rvalid(m1_rvalid_a), .m1_rdata(m1_rdata_a),
    .ram_en(ram_en_a), .ram_we(ram_we_a), .ram_addr(ram_addr_a),
    .ram_di(ram_di_a), .ram_do(ram_do_a)
  );

  dffram_arbiter #(.FIXED_PRIO(1)) u_fp (
    .CLK(clk), .RST(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt_b), .m0_rvalid(m0_rvalid_b), .m0_rdata(m0_rdata_b),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt_b), .m1_rvalid(m1_rvalid_b), .m1_rdata(m1_rdata_b),
    .ram_en(ram_en_b), .ram_we(ram_we_b), .ram_addr(ram_addr_b),
    .ram_di(ram_di_b), .ram_do(32'h0)
  );

  // Behavioural DFFRAM for the round-robin DUT: registered output, zero when disabled.
  logic [31:0] mem_a [256] = '{default: 32'h0};
  always @(posedge clk) begin
    if (ram_en_a) begin
      ram_do_a <= mem_a[ram_addr_a];
      for (int b = 0; b < 4; b++)
        if (ram_we_a[b]) mem_a[ram_addr_a][8*b +: 8] <= ram_di_a[8*b +: 8];
    end else begin
      ram_do_a <= 32'h0;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  // Reference model state
  typedef struct { logic [31:0] data; int cyc; } rd_t;
  rd_t         rq [2][$];
  logic [31:0] ref_mem [256];
  logic [31:0] hold_exp [2] = '{32'h0, 32'h0};
  int          last_w = 1;
  bit          p_req [2] = '{0, 0};
  logic [3:0]  p_we [2];
  logic [7:0]  p_addr [2];
  logic [31:0] p_wd [2];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] we);
    logic [31:0] mask;
    mask = {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
    return (old & ~mask) | (wd & mask);
  endfunction

  task automatic arm(input int who, input logic [3:0] we, input logic [7:0] addr,
                     input logic [31:0] wd);
    p_req[who] = 1; p_we[who] = we; p_addr[who] = addr; p_wd[who] = wd;
  endtask

  task automatic step(input bit r);
    int w;
    logic [1:0] eb;
    logic [1:0] ea;
    @(posedge clk); #1;
    rst = r;
    m0_req = p_req[0]; m0_we = p_we[0]; m0_addr = p_addr[0]; m0_wdata = p_wd[0];
    m1_req = p_req[1]; m1_we = p_we[1]; m1_addr = p_addr[1]; m1_wdata = p_wd[1];
    w = -1;
    if (!r) begin
      if (p_req[0] && p_req[1]) w = (last_w == 1) ? 0 : 1;
      else if (p_req[0])        w = 0;
      else if (p_req[1])        w = 1;
    end
    eb = r ? 2'b00 : (p_req[0] ? 2'b01 : (p_req[1] ? 2'b10 : 2'b00));
    ea = (w < 0) ? 2'b00 : ((w == 0) ? 2'b01 : 2'b10);
    @(negedge clk);
    chk("gnt_rr", {62'h0, m1_gnt_a, m0_gnt_a}, {62'h0, ea});
    chk("gnt_fp", {62'h0, m1_gnt_b, m0_gnt_b}, {62'h0, eb});
    chk("ram_en", {63'h0, ram_en_a}, {63'h0, (w >= 0)});
    if (w >= 0) begin
      chk("ram_port", {20'h0, ram_we_a, ram_addr_a, ram_di_a},
          {20'h0, p_we[w], p_addr[w], p_wd[w]});
      if (p_we[w] == 4'h0) rq[w].push_back('{ref_mem[p_addr[w]], cyc});
      else ref_mem[p_addr[w]] = merge(ref_mem[p_addr[w]], p_wd[w], p_we[w]);
      last_w = w;
      p_req[w] = 0;
    end else begin
      chk("ram_idle", {20'h0, ram_we_a, ram_addr_a, ram_di_a}, 64'h0);
    end
    if (r) last_w = 1;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && (p_req[0] || p_req[1]); k++) step(0);
    chk("drain", {62'h0, p_req[1], p_req[0]}, 64'h0);
  endtask

  // Monitor: pops expected read data when rvalid appears; otherwise checks the hold value.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic        rv;
      logic [31:0] rd;
      rd_t         e;
      rv = (i == 0) ? m0_rvalid_a : m1_rvalid_a;
      rd = (i == 0) ? m0_rdata_a  : m1_rdata_a;
      if (rv) begin
        if (rq[i].size() == 0) begin
          chk(i == 0 ? "m0_rvalid_unexpected" : "m1_rvalid_unexpected", 64'd1, 64'd0);
        end else begin
          e = rq[i].pop_front();
          chk(i == 0 ? "m0_rdata" : "m1_rdata", {32'h0, rd}, {32'h0, e.data});
          hold_exp[i] = e.data;
        end
      end else begin
        if (rq[i].size() != 0 && rq[i][0].cyc == cyc - 1) begin
          e = rq[i].pop_front();
          chk(i == 0 ? "m0_rvalid_missing" : "m1_rvalid_missing", 64'd0, 64'd1);
        end
        chk(i == 0 ? "m0_hold" : "m1_hold", {32'h0, rd}, {32'h0, hold_exp[i]});
      end
    end
    if (rst) begin
      hold_exp[0] = 32'h0;
      hold_exp[1] = 32'h0;
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
    for (int i = 0; i < 2; i++) begin
      p_we[i] = '0; p_addr[i] = '0; p_wd[i] = '0;
    end

    // Reset state with requests pending: nothing may be granted.
    step(1);
    arm(0, 4'h0, 8'h05, 32'h0);
    step(1);
    chk("rst_outputs", {60'h0, m0_gnt_a, m1_gnt_a, m0_rvalid_a, ram_en_a}, 64'h0);
    p_req[0] = 0;
    step(0);

    // m0 write then read 0x10
    arm(0, 4'hF, 8'h10, 32'hDEADBEEF); drain();
    arm(0, 4'h0, 8'h10, 32'h0);        drain();
    step(0);
    chk("m0_deadbeef", {32'h0, m0_rdata_a}, 64'hDEADBEEF);

    // m1 full write, partial byte write, read back
    arm(1, 4'hF, 8'h20, 32'h000000AA); drain();
    arm(1, 4'h2, 8'h20, 32'h0000BB00); drain();
    arm(1, 4'h0, 8'h20, 32'h0);        drain();
    step(0); step(0);
    chk("m1_bbaa_hold", {32'h0, m1_rdata_a}, 64'h0000BBAA);

    // Continuous contention: reads of addr 1 / addr 2
    arm(0, 4'hF, 8'h01, 32'h11111111); drain();
    arm(1, 4'hF, 8'h02, 32'h22222222); drain();
    for (int k = 0; k < 8; k++) begin
      arm(0, 4'h0, 8'h01, 32'h0);
      arm(1, 4'h0, 8'h02, 32'h0);
      step(0);
    end
    p_req[0] = 0;
    arm(1, 4'h0, 8'h02, 32'h0);
    step(0);
    chk("m0_drop_m1_wins_fp", {63'h0, m1_gnt_b}, 64'h1);
    p_req[1] = 0;

    // Read of 0x10, reset next cycle, then contention grants m0 first
    arm(0, 4'h0, 8'h10, 32'h0);
    step(0);
    arm(0, 4'h0, 8'h03, 32'h0);
    arm(1, 4'h0, 8'h04, 32'h0);
    step(1);
    chk("rst_rvalid_kept", {31'h0, m0_rvalid_a, m0_rdata_a}, {31'h0, 1'b1, 32'hDEADBEEF});
    step(0);
    chk("post_rst_m0_first", {62'h0, m1_gnt_a, m0_gnt_a}, 64'h1);
    drain();

    // Idle gap
    for (int k = 0; k < 4; k++) step(0);

    // Random traffic with occasional reset
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!p_req[i] && $urandom_range(0, 2) != 0) begin
          arm(i, ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
              8'($urandom_range(0, 7)), $urandom);
        end
      end
      step($urandom_range(0, 63) == 0);
    end
    p_req[0] = 0; p_req[1] = 0;
    for (int k = 0; k < 3; k++) step(0);
    chk("queues_empty", 64'(rq[0].size() + rq[1].size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dffram_arbiter.md
# dffram_arbiter

Two-requester access arbiter for the single-port 256x32 DFFRAM macro used for SNN neuron-state and weight storage. Lets the neuron update engine (m0) and the config/host loader (m1) share one RAM port: each cycle it grants at most one request with round-robin or fixed priority, drives the RAM port, and routes the registered read data back with a one-cycle return. A per-requester hold register keeps each requester's last read data stable. This matters because the RAM drives zero on its output whenever it is not enabled.

## Interface
Parameters:
- FIXED_PRIO, 0, 0 = round-robin between m0/m1; 1 = m0 always wins.
- ADDR_W, 8, RAM address width (256 words).
- DATA_W, 32, RAM data width; NB = DATA_W/8 byte lanes.

Ports:
- CLK  in  1  single clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- m0_req, m1_req  in  1  request valid; held with its fields until granted.
- m0_we, m1_we  in  NB  byte write enables; all-zero = read.
- m0_addr, m1_addr  in  ADDR_W  word address.
- m0_wdata, m1_wdata  in  DATA_W  write data.
- m0_gnt, m1_gnt  out  1  combinational accept; request consumed in this cycle.
- m0_rvalid, m1_rvalid  out  1  one-cycle pulse: read data present on mX_rdata.
- m0_rdata, m1_rdata  out  DATA_W  read data; stable between rvalid pulses.
- ram_en  out  1  RAM EN0.
- ram_we  out  NB  RAM WE0.
- ram_addr  out  ADDR_W  RAM A0.
- ram_di  out  DATA_W  RAM Di0.
- ram_do  in  DATA_W  RAM Do0 (registered in the macro; zero when not enabled).

## Operation
- Grant (combinational, same cycle):
  - Only one requester: it wins.
  - Both requesting, FIXED_PRIO=1: m0 wins.
  - Both requesting, FIXED_PRIO=0: the requester not granted last wins.
  - Grants are forced to 0 while RST=1.
- last_gnt register: updated only on a grant. Reset value selects m1, so m0 wins the first contention.
- RAM drive:
  - On a grant: ram_en=1 and ram_we/addr/di come from the winner.
  - Otherwise: ram_en=0 and ram_we, ram_addr and ram_di are all 0.
- Read tracking: a granted request with we==0 sets rd_pend[X] for the next cycle. Granted writes, including partial byte writes, never produce rvalid.
- Read return: mX_rvalid = rd_pend[X]. mX_rdata = ram_do while rd_pend[X], else hold[X]. hold[X] captures ram_do at the end of every rd_pend[X] cycle.
- Read-after-write to the same address in consecutive cycles returns the new data: the write commits at the edge ending the write cycle.
- A request arriving at the same address as a write granted in the same cycle is not possible; only one access exists per cycle.
- Requesters must hold req and all fields stable until gnt. The arbiter does not register requests.

## Timing
- Read latency: grant in cycle t, then mX_rvalid=1 and data in cycle t+1. Back-to-back reads give one read per cycle.
- Write: commits at the end of the grant cycle.
- Throughput: 1 access/cycle total. Under continuous contention in round-robin mode, grants alternate m0,m1,m0,...
- Reset values: last_gnt=m1, rd_pend=0, hold[0]=hold[1]=0. All outputs 0 during and after reset until the first request.
- Reset mid-operation, RST high in cycle t:
  - No grant and ram_en=0 in cycle t.
  - A read granted in t-1 still pulses rvalid in t; its data is valid.
  - All rvalid are 0 in t+1, and hold registers read 0 from t+1.
- Simultaneous read return to mX and new grant to mX in the same cycle is legal: return belongs to the previous access.

## Structure
- Shared package snn_mem_pkg:
  - Constants SNN_RAM_ADDR_W=8, SNN_RAM_DATA_W=32, SNN_RAM_NB=4.
  - Requester-id enum {REQ_M0, REQ_M1}.
- Sub-module rr_arb2: 2-way round-robin/fixed-priority grant with a last_gnt register. Inputs req[1:0], FIXED_PRIO parameter, CLK, RST; output gnt[1:0] one-hot or zero.
- Top holds the RAM port mux, the rd_pend pipeline and the hold registers. The DFFRAM macro is instantiated outside, by the parent.

## Test plan
- m0 writes 0xDEADBEEF with we=4'hF to addr 0x10, then reads 0x10 → m0_gnt both cycles; m0_rvalid one cycle later with 0xDEADBEEF; m1_rvalid stays 0.
- m1 writes 0x000000AA to 0x20 with we=4'hF, then 0x0000BB00 with we=4'h2, then reads 0x20 → m1_rdata=0x0000BBAA. No rvalid on the write cycles.
- Both requesters read continuously (m0 addr 1, m1 addr 2), FIXED_PRIO=0 → grants m0,m1,m0,m1. Each rvalid pulses every other cycle with the correct word. Each rdata holds between pulses.
- Same contention with FIXED_PRIO=1 → m0_gnt every cycle and m1_gnt never. When m0_req drops, m1 is granted in that same cycle.
- Read of 0x10 granted, RST asserted the next cycle → rvalid with 0xDEADBEEF still seen in the RST cycle. Then all outputs are 0, and the first contention after reset grants m0.
- Idle cycles between reads → ram_en=0 and ram_addr/di/we=0. mX_rdata keeps the last read value even though ram_do is 0.
